// File: rtl/mips_cpu_instr_mem_if.sv
// Fetch bus between the PC/fetch logic (master) and the instruction memory (slave).
interface mips_cpu_instr_mem_if;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        fault;

    modport master (output address, read, input waitrequest, readdata, fault);
    modport slave  (input address, read, output waitrequest, readdata, fault);
endinterface

// File: rtl/mips_cpu_instr_mem.sv
// Instruction-fetch responder: ROM window at the reset vector with a bring-up load port,
// stalling each fetch for WAIT_CYCLES before returning the word.
module mips_cpu_instr_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2,
    localparam int         AW          = $clog2(DEPTH),
    localparam int         CW          = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    mips_cpu_instr_mem_if.slave     bus,
    input  logic                    load_en,
    input  logic [AW-1:0]           load_index,
    input  logic [31:0]             load_data
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    readdata_q, readdata_d;
    logic           fault_q, fault_d;
    logic [31:0]    mem_q [DEPTH];

    logic [31:0]    lk_addr, lk_off, lk_idx, lk_data;
    logic           lk_fault;

    // With no wait states RESP is entered straight from IDLE, so look up the live address there.
    always_comb begin
        lk_addr  = (state_q == S_IDLE) ? bus.address : addr_q;
        lk_off   = lk_addr - BASE_ADDR;
        lk_idx   = lk_off >> 2;
        lk_data  = 32'd0;
        lk_fault = 1'b0;
        if (lk_addr != 32'd0) begin
            if (lk_addr[1:0] != 2'b00) begin
                lk_fault = 1'b1;
            end else if (lk_idx >= 32'(DEPTH)) begin
                lk_fault = 1'b1;
            end else begin
                lk_data = mem_q[lk_idx[AW-1:0]];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        readdata_d = readdata_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (bus.read) begin
                    addr_d = bus.address;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        readdata_d = lk_data;
                        fault_d    = lk_fault;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (!bus.read) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d    = S_RESP;
                    cnt_d      = '0;
                    readdata_d = lk_data;
                    fault_d    = lk_fault;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            readdata_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            readdata_q <= readdata_d;
            fault_q    <= fault_d;
        end
    end

    // Array is deliberately outside reset; loads land even while rst is high.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_index] <= load_data;
        end
    end

    assign bus.waitrequest = bus.read & (state_q != S_RESP);
    assign bus.readdata    = readdata_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_mips_cpu_instr_mem.sv
// Self-checking bench: two instances (0 and 2 wait states) against an array-based fetch model.
module tb_mips_cpu_instr_mem;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_cpu_instr_mem_if bus0 ();
    mips_cpu_instr_mem_if bus2 ();
    logic        le0, le2;
    logic [9:0]  li0, li2;
    logic [31:0] ld0, ld2;

    mips_cpu_instr_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .load_en(le0), .load_index(li0), .load_data(ld0));
    mips_cpu_instr_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .load_en(le2), .load_index(li2), .load_data(ld2));

    // d = 0 selects dut0, d = 1 selects dut2
    logic [31:0] mdl [2][DEPTH];
    int          wcyc [2];
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [32:0] ref_lookup(int d, logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a == 32'd0)           return {1'b0, 32'd0};
        if (a % 4 != 0)           return {1'b1, 32'd0};
        if (off / 4 >= DEPTH)     return {1'b1, 32'd0};
        return {1'b0, mdl[d][off / 4]};
    endfunction

    task automatic drv(int d, logic rd, logic [31:0] a);
        if (d == 0) begin bus0.read = rd; bus0.address = a; end
        else        begin bus2.read = rd; bus2.address = a; end
    endtask

    task automatic drv_load(int d, logic en, logic [9:0] i, logic [31:0] v);
        if (d == 0) begin le0 = en; li0 = i; ld0 = v; end
        else        begin le2 = en; li2 = i; ld2 = v; end
    endtask

    function automatic logic wr(int d);
        return (d == 0) ? bus0.waitrequest : bus2.waitrequest;
    endfunction
    function automatic logic [31:0] rdat(int d);
        return (d == 0) ? bus0.readdata : bus2.readdata;
    endfunction
    function automatic logic flt(int d);
        return (d == 0) ? bus0.fault : bus2.fault;
    endfunction

    task automatic do_load(int d, logic [9:0] i, logic [31:0] v);
        @(posedge clk); #1;
        drv_load(d, 1'b1, i, v);
        mdl[d][i] = v;
        @(posedge clk); #1;
        drv_load(d, 1'b0, '0, '0);
    endtask

    // One fetch; optional address scrambling while stalled and an optional load in cycle load_cyc.
    task automatic fetch(int d, logic [31:0] a, bit scramble, int load_cyc,
                         logic [9:0] lidx, logic [31:0] lval, string nm);
        logic [32:0] e_old, e;
        int cyc;
        bit done;
        e_old = ref_lookup(d, a);
        done  = 1'b0;
        @(posedge clk); #1;
        drv(d, 1'b1, a);
        for (cyc = 1; cyc <= 10; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
                if (scramble) drv(d, 1'b1, $urandom);
            end
            drv_load(d, cyc == load_cyc, lidx, lval);
            if (cyc == load_cyc) mdl[d][lidx] = lval;
            @(negedge clk);
            if (!wr(d)) begin done = 1'b1; break; end
        end
        e = (load_cyc == wcyc[d] + 1) ? e_old : ref_lookup(d, a);
        n_chk++;
        if (!done || cyc != wcyc[d] + 2) begin
            n_fail++;
            $display("FAIL %s latency: response cycle %0d, required %0d", nm, cyc, wcyc[d] + 2);
        end
        n_chk++;
        if (rdat(d) !== e[31:0]) begin
            n_fail++;
            $display("FAIL %s readdata: got %h, required %h (addr %h)", nm, rdat(d), e[31:0], a);
        end
        n_chk++;
        if (flt(d) !== e[32]) begin
            n_fail++;
            $display("FAIL %s fault: got %b, required %b (addr %h)", nm, flt(d), e[32], a);
        end
        @(posedge clk); #1;
        drv(d, 1'b0, a);
        drv_load(d, 1'b0, '0, '0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(1, 3);
            2:       return BASE + 4 * DEPTH + ($urandom_range(0, 1000) << 2);
            3:       return $urandom_range(1, 1000) << 2;
            default: return BASE + ($urandom_range(0, DEPTH - 1) << 2);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drv(0, 1'b0, '0); drv(1, 1'b0, '0);
        drv_load(0, 1'b0, '0, '0); drv_load(1, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (wr(d) !== 1'b0) begin n_fail++; $display("FAIL reset waitrequest[%0d]: got %b, required 0", d, wr(d)); end
            n_chk++;
            if (rdat(d) !== 32'd0) begin n_fail++; $display("FAIL reset readdata[%0d]: got %h, required 0", d, rdat(d)); end
            n_chk++;
            if (flt(d) !== 1'b0) begin n_fail++; $display("FAIL reset fault[%0d]: got %b, required 0", d, flt(d)); end
        end
    endtask

    task automatic bulk_load();
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                logic [31:0] v;
                v = $urandom;
                drv_load(d, 1'b1, 10'(i), v);
                mdl[d][i] = v;
            end
        end
        @(posedge clk); #1;
        drv_load(0, 1'b0, '0, '0); drv_load(1, 1'b0, '0, '0);
    endtask

    task automatic test_first_fetch();
        do_load(1, 10'd0, 32'h24080005);
        fetch(1, BASE, 1'b0, 0, '0, '0, "first_fetch");
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        drv(0, 1'b1, BASE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (wr(0) !== 1'b1) begin n_fail++; $display("FAIL b2b stall %0d: waitrequest %b, required 1", i, wr(0)); end
            @(negedge clk);
            n_chk++;
            if (wr(0) !== 1'b0 || rdat(0) !== mdl[0][i]) begin
                n_fail++;
                $display("FAIL b2b word %0d: waitrequest %b data %h, required 0 / %h", i, wr(0), rdat(0), mdl[0][i]);
            end
            @(posedge clk); #1;
            drv(0, 1'b1, BASE + 32'(4 * (i + 1)));
        end
        drv(0, 1'b0, '0);
    endtask

    task automatic test_lookup_edges();
        for (int d = 0; d < 2; d++) begin
            fetch(d, 32'd0,           1'b0, 0, '0, '0, "halt_addr");
            fetch(d, BASE + 32'd2,    1'b0, 0, '0, '0, "misaligned");
            fetch(d, BASE + 4 * DEPTH,1'b0, 0, '0, '0, "past_window");
            fetch(d, 32'd4,           1'b0, 0, '0, '0, "below_base");
            fetch(d, BASE + 4 * (DEPTH - 1), 1'b0, 0, '0, '0, "last_word");
        end
    endtask

    task automatic test_abort();
        do_load(1, 10'd10, 32'h11111111);
        fetch(1, BASE + 32'd40, 1'b0, 0, '0, '0, "pre_abort");
        @(posedge clk); #1;
        drv(1, 1'b1, BASE + 32'd2);
        @(posedge clk); #1;
        drv(1, 1'b0, BASE + 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (rdat(1) !== 32'h11111111 || flt(1) !== 1'b0 || wr(1) !== 1'b0) begin
                n_fail++;
                $display("FAIL abort hold %0d: data %h fault %b wait %b, required 11111111 / 0 / 0",
                         i, rdat(1), flt(1), wr(1));
            end
        end
        fetch(1, BASE + 32'd44, 1'b1, 0, '0, '0, "post_abort");
    endtask

    task automatic test_load_race();
        do_load(1, 10'd1, 32'h0BADF00D);
        fetch(1, BASE + 32'd4, 1'b0, 2, 10'd1, 32'hDEADBEEF, "load_in_wait");
        do_load(1, 10'd1, 32'h0BADF00D);
        fetch(1, BASE + 32'd4, 1'b0, 3, 10'd1, 32'hDEADBEEF, "load_on_resp_edge");
        fetch(1, BASE + 32'd4, 1'b0, 0, '0, '0, "after_load");
        fetch(0, BASE + 32'd8, 1'b0, 1, 10'd2, 32'hCAFEF00D, "w0_load_same_edge");
        fetch(0, BASE + 32'd8, 1'b0, 0, '0, '0, "w0_after_load");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int d;
            int lc;
            logic [31:0] a;
            d  = n % 2;
            a  = rand_addr();
            lc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, wcyc[d] + 1)) : 0;
            fetch(d, a, 1'($urandom_range(0, 1)), lc, 10'((a - BASE) >> 2), $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] nv;
        int cyc;
        bit done;
        nv = $urandom;
        do_load(1, 10'd5, 32'h55AA55AA);
        fetch(1, BASE + 32'd40, 1'b0, 0, '0, '0, "pre_reset");
        @(posedge clk); #1;
        drv(1, 1'b1, BASE + 32'd20);
        @(posedge clk); #1;
        rst = 1'b1;
        drv_load(1, 1'b1, 10'd7, nv);
        @(posedge clk); #1;
        rst = 1'b0;
        drv_load(1, 1'b0, '0, '0);
        mdl[1][7] = nv;
        @(negedge clk);
        n_chk++;
        if (wr(1) !== 1'b1 || rdat(1) !== 32'd0 || flt(1) !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid wait/data/fault: %b %h %b, required 1 00000000 0", wr(1), rdat(1), flt(1));
        end
        done = 1'b0;
        for (cyc = 3; cyc <= 12; cyc++) begin
            if (cyc > 3) @(negedge clk);
            if (!wr(1)) begin done = 1'b1; break; end
        end
        n_chk++;
        if (!done || cyc != 6) begin
            n_fail++;
            $display("FAIL rst_mid latency: response cycle %0d, required 6", cyc);
        end
        n_chk++;
        if (rdat(1) !== 32'h55AA55AA || flt(1) !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid data: got %h/%b, required 55aa55aa/0", rdat(1), flt(1));
        end
        @(posedge clk); #1;
        drv(1, 1'b0, '0);
        fetch(1, BASE + 32'd28, 1'b0, 0, '0, '0, "load_during_rst");
    endtask

    initial begin
        wcyc[0] = 0;
        wcyc[1] = 2;
        test_reset();
        bulk_load();
        test_first_fetch();
        test_back_to_back();
        test_lookup_edges();
        test_abort();
        test_load_race();
        test_random();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
